oe_split_scheduler: RTL

- Operand-side counterpart of the 41-bit overlap recombiner.
- Accepts two 42-bit GF(2) polynomial operands A and B and splits each into even-indexed and odd-indexed 21-bit halves.
- Issues the four half-operand pairs, one per handshake beat, to a shared 21x21 polynomial multiplier. The four products are later reassembled by the overlap recombiner.
- Sits between the operand source and the sub-multiplier in the OBS level-4 datapath.

---
 rtl/oe_split_scheduler_pkg.sv | 22 ++
 rtl/oe_split_scheduler_deinterleave.sv | 24 ++
 rtl/oe_split_scheduler.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/oe_split_scheduler_pkg.sv
// Shared constants and types for the even/odd operand split scheduler.
// Latency: none; this file holds only types and constants.
// Backpressure: none.
package oe_split_scheduler_pkg;

   localparam int OBS_N = 42;
   localparam int OBS_H = 21;

   // Beat order on the sub-multiplier port; value k feeds recombiner input in(k+1)
   typedef enum logic [1:0] {
      BEAT_EE = 2'd0,
      BEAT_EO = 2'd1,
      BEAT_OE = 2'd2,
      BEAT_OO = 2'd3
   } beat_e;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_ISSUE = 1'b1
   } state_e;

endpackage

// File: rtl/oe_split_scheduler_deinterleave.sv
// Even/odd coefficient splitter: even_o[i] = din[2i], odd_o[i] = din[2i+1].
// Latency: purely combinational.
// Backpressure: none; the split is pure wiring.
module oe_deinterleave
   import oe_split_scheduler_pkg::*;
#(
   parameter int N = OBS_N
) (
   input  logic [N-1:0]   din,
   output logic [N/2-1:0] even_o,
   output logic [N/2-1:0] odd_o
);

   // Gather alternate coefficients into two half-width polynomials
   always_comb begin
      even_o = '0;
      odd_o  = '0;
      for (int i = 0; i < N / 2; i++) begin
         even_o[i] = din[2*i];
         odd_o[i]  = din[2*i+1];
      end
   end

endmodule

// File: rtl/oe_split_scheduler.sv
// Splits A,B into even/odd halves and issues (Ae,Be),(Ae,Bo),(Ao,Be),(Ao,Bo) to a shared 21x21 multiplier.
// Latency: first beat valid the cycle after accept; 4 beats per block; 1-cycle bubble between blocks.
// Backpressure: beats hold stable while out_ready is low; OE_SPLIT_PREFETCH_EN adds a 1-entry buffer for zero-bubble blocks.
module oe_split_scheduler
   import oe_split_scheduler_pkg::*;
#(
   parameter  int N = OBS_N,
   localparam int H = N / 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] A_in,
   input  logic [N-1:0] B_in,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [H-1:0] out_a,
   output logic [H-1:0] out_b,
   output logic [1:0]   out_idx,
   output logic         out_last,
   output logic         busy
);

   // Operands are held already split, so the beat mux is a plain 2:1 select per side
   typedef struct packed {
      logic [H-1:0] ae;
      logic [H-1:0] ao;
      logic [H-1:0] be;
      logic [H-1:0] bo;
   } halves_t;

   state_e     state_q, state_d;
   logic [1:0] idx_q, idx_d;
   halves_t    ops_q, ops_d;
   halves_t    in_ops;

   logic [H-1:0] a_even, a_odd, b_even, b_odd;
   logic         in_fire, out_fire, last_fire;

   oe_deinterleave #(.N(N)) u_split_a (
      .din    (A_in),
      .even_o (a_even),
      .odd_o  (a_odd)
   );

   oe_deinterleave #(.N(N)) u_split_b (
      .din    (B_in),
      .even_o (b_even),
      .odd_o  (b_odd)
   );

   assign in_ops = {a_even, a_odd, b_even, b_odd};

`ifdef OE_SPLIT_PREFETCH_EN
   logic    buf_vld_q, buf_vld_d;
   halves_t buf_q, buf_d;

   assign in_ready = !buf_vld_q;
   assign busy     = (state_q == ST_ISSUE) || buf_vld_q;
`else
   assign in_ready = (state_q == ST_IDLE);
   assign busy     = (state_q == ST_ISSUE);
`endif

   assign out_valid = (state_q == ST_ISSUE);
   assign out_idx   = idx_q;
   assign out_last  = (idx_q == BEAT_OO);
   // idx bit 1 selects the odd half of A, bit 0 the odd half of B
   assign out_a     = idx_q[1] ? ops_q.ao : ops_q.ae;
   assign out_b     = idx_q[0] ? ops_q.bo : ops_q.be;

   assign in_fire   = in_valid && in_ready;
   assign out_fire  = out_valid && out_ready;
   assign last_fire = out_fire && (idx_q == BEAT_OO);

   // Next-state: accept in IDLE, step the beat index on each handshake, end or chain on the last beat
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      ops_d   = ops_q;
`ifdef OE_SPLIT_PREFETCH_EN
      buf_vld_d = buf_vld_q;
      buf_d     = buf_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (in_fire) begin
               ops_d   = in_ops;
               idx_d   = BEAT_EE;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (out_fire) begin
               idx_d = idx_q + 2'd1;
            end
`ifdef OE_SPLIT_PREFETCH_EN
            if (last_fire && buf_vld_q) begin
               ops_d     = buf_q;
               buf_vld_d = 1'b0;
            end else if (last_fire && in_fire) begin
               // Buffer is empty and the block ends now: load straight into the issue registers
               ops_d = in_ops;
            end else if (last_fire) begin
               state_d = ST_IDLE;
            end else if (in_fire) begin
               buf_d     = in_ops;
               buf_vld_d = 1'b1;
            end
`else
            if (last_fire) begin
               state_d = ST_IDLE;
            end
`endif
         end
         default: begin
            state_d = ST_IDLE;
            idx_d   = BEAT_EE;
         end
      endcase
   end

   // State, beat index and issue operand registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         idx_q   <= BEAT_EE;
         ops_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         ops_q   <= ops_d;
      end
   end

`ifdef OE_SPLIT_PREFETCH_EN
   // One-entry prefetch buffer holding the next block's split operands
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buf_vld_q <= 1'b0;
         buf_q     <= '0;
      end else begin
         buf_vld_q <= buf_vld_d;
         buf_q     <= buf_d;
      end
   end
`endif

endmodule
